// File: rtl/register_file_if.sv
// Issue, writeback and read-port bundle for register_file.
// The master drives addresses, issue and writeback; the slave returns read data and stall.
interface register_file_if;
  logic [6:0]   ra_addr;
  logic [6:0]   rb_addr;
  logic         issue_valid;
  logic [6:0]   issue_rt_addr;
  logic         issue_reg_write;
  logic [127:0] rt_wb;
  logic [6:0]   rt_addr_wb;
  logic         reg_write_wb;
  logic [127:0] ra;
  logic [127:0] rb;
  logic         stall;

  modport master (
    output ra_addr, rb_addr, issue_valid, issue_rt_addr, issue_reg_write,
           rt_wb, rt_addr_wb, reg_write_wb,
    input  ra, rb, stall
  );

  modport slave (
    input  ra_addr, rb_addr, issue_valid, issue_rt_addr, issue_reg_write,
           rt_wb, rt_addr_wb, reg_write_wb,
    output ra, rb, stall
  );
endinterface

// File: rtl/register_file.sv
// 128 x 128-bit register file with two registered read ports and a busy-bit scoreboard.
// Define RF_BYPASS_EN to forward same-cycle writeback data and clears to reads and the hazard check.
module register_file (
  input  logic           clk,
  input  logic           reset,
  register_file_if.slave rf
);

  logic [127:0] mem [128];
  logic [127:0] busy;
  logic [127:0] busy_eff;
  logic [127:0] ra_next;
  logic [127:0] rb_next;
  logic         issue_accept;

  // busy_eff is the scoreboard as seen by this cycle's hazard check.
  always_comb begin
    busy_eff = busy;
`ifdef RF_BYPASS_EN
    if (rf.reg_write_wb) busy_eff[rf.rt_addr_wb] = 1'b0;
`endif
  end

  assign rf.stall = rf.issue_valid &
                    (busy_eff[rf.ra_addr] | busy_eff[rf.rb_addr] |
                     (rf.issue_reg_write & busy_eff[rf.issue_rt_addr]));

  assign issue_accept = rf.issue_valid & ~rf.stall;

  always_comb begin
    ra_next = mem[rf.ra_addr];
    rb_next = mem[rf.rb_addr];
`ifdef RF_BYPASS_EN
    if (rf.reg_write_wb && (rf.rt_addr_wb == rf.ra_addr)) ra_next = rf.rt_wb;
    if (rf.reg_write_wb && (rf.rt_addr_wb == rf.rb_addr)) rb_next = rf.rt_wb;
`endif
  end

  // NOTE: storage must read as zero while reset is held, so every entry is a
  // flop with async reset rather than an inferred RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) mem[i] <= '0;
    end else if (rf.reg_write_wb) begin
      mem[rf.rt_addr_wb] <= rf.rt_wb;
    end
  end

  // NOTE: the set is written after the clear, and the last non-blocking
  // assignment to the same bit wins, so a same-cycle set beats the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (rf.reg_write_wb) busy[rf.rt_addr_wb] <= 1'b0;
      if (issue_accept && rf.issue_reg_write) busy[rf.issue_rt_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf.ra <= '0;
      rf.rb <= '0;
    end else begin
      rf.ra <= ra_next;
      rf.rb <= rb_next;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios then random traffic
// against an array/bit-vector reference model of storage and scoreboard.
module tb_register_file;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic reset;
  register_file_if bus ();

  register_file dut (
    .clk   (clk),
    .reset (reset),
    .rf    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [127:0] m_mem  [128];
  bit           m_busy [128];
  logic [127:0] exp_ra;
  logic [127:0] exp_rb;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 128; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    exp_ra = '0;
    exp_rb = '0;
  endtask

  // Busy as seen by the hazard check: a same-cycle writeback hides it only with bypass.
  function automatic bit seen_busy(input logic [6:0] a, input logic we, input logic [6:0] wa);
    return m_busy[a] && !(BYP && we && (wa == a));
  endfunction

  // One cycle, entered and left at a falling edge.
  task automatic step(input logic [6:0] a, input logic [6:0] b, input logic v,
                      input logic [6:0] rt, input logic rw, input logic we,
                      input logic [6:0] wa, input logic [127:0] wd, output logic st_obs);
    bit st_exp;
    bus.ra_addr = a;  bus.rb_addr = b;
    bus.issue_valid = v; bus.issue_rt_addr = rt; bus.issue_reg_write = rw;
    bus.reg_write_wb = we; bus.rt_addr_wb = wa; bus.rt_wb = wd;
    #1;
    st_exp = v && (seen_busy(a, we, wa) || seen_busy(b, we, wa) || (rw && seen_busy(rt, we, wa)));
    check("stall", {127'd0, bus.stall}, {127'd0, st_exp});
    st_obs = bus.stall;
    exp_ra = (BYP && we && wa == a) ? wd : m_mem[a];
    exp_rb = (BYP && we && wa == b) ? wd : m_mem[b];
    if (we) begin
      m_mem[wa]  = wd;
      m_busy[wa] = 1'b0;
    end
    if (v && !st_exp && rw) m_busy[rt] = 1'b1;
    @(posedge clk);
    #1;
    check("ra", bus.ra, exp_ra);
    check("rb", bus.rb, exp_rb);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.ra_addr = '0; bus.rb_addr = '0;
    bus.issue_valid = 1'b0; bus.issue_rt_addr = '0; bus.issue_reg_write = 1'b0;
    bus.reg_write_wb = 1'b0; bus.rt_addr_wb = '0; bus.rt_wb = '0;
  endtask

  localparam logic [127:0] PAT  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] D40  = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

  initial begin
    logic st;
    reset = 1'b0;
    idle_inputs();
    model_clear();

    // Reset with no clock edge yet: outputs clear immediately.
    #1 reset = 1'b1;
    bus.issue_valid = 1'b1;
    #1;
    check("rst_ra", bus.ra, '0);
    check("rst_rb", bus.rb, '0);
    check("rst_stall", {127'd0, bus.stall}, '0);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();

    step(7'd5, 7'd127, 0, 0, 0, 0, 0, '0, st);
    check("rst_rd5", bus.ra, '0);
    check("rst_rd127", bus.rb, '0);

    // Writeback then read.
    step(7'd0, 7'd0, 0, 0, 0, 1, 7'd3, PAT, st);
    step(7'd3, 7'd3, 0, 0, 0, 0, 0, '0, st);
    check("wr_rd3", bus.ra, PAT);
    check("dual_rd3", bus.rb, PAT);

    // RAW hazard on 10, cleared by writeback.
    step(7'd0, 7'd0, 1, 7'd10, 1, 0, 0, '0, st);
    check("iss10_acc", {127'd0, st}, '0);
    step(7'd10, 7'd0, 1, 7'd0, 0, 0, 0, '0, st);
    check("raw10", {127'd0, st}, 128'd1);
    step(7'd10, 7'd0, 1, 7'd0, 0, 1, 7'd10, 128'h55, st);
    check("raw10_wb", {127'd0, st}, {127'd0, !BYP});
    step(7'd10, 7'd0, 1, 7'd0, 0, 0, 0, '0, st);
    check("raw10_after", {127'd0, st}, '0);

    // Same-cycle writeback to a read address.
    step(7'd7, 7'd0, 0, 0, 0, 1, 7'd7, ONES, st);
    check("byp7", bus.ra, BYP ? ONES : 128'd0);

    // Set beats clear on a free address.
    step(7'd0, 7'd0, 1, 7'd21, 1, 1, 7'd21, 128'h21, st);
    step(7'd21, 7'd0, 1, 7'd0, 0, 0, 0, '0, st);
    check("setwins21", {127'd0, st}, 128'd1);
    step(7'd0, 7'd0, 0, 0, 0, 1, 7'd21, 128'h22, st);

    // Busy 20, then issue to 20 alongside its writeback.
    step(7'd0, 7'd0, 1, 7'd20, 1, 0, 0, '0, st);
    step(7'd0, 7'd0, 1, 7'd20, 1, 1, 7'd20, 128'h20, st);
    check("iss20_wb", {127'd0, st}, {127'd0, !BYP});
    step(7'd20, 7'd0, 1, 7'd0, 0, 0, 0, '0, st);
    check("busy20", {127'd0, st}, {127'd0, BYP});
    step(7'd0, 7'd0, 0, 0, 0, 1, 7'd20, 128'h2020, st);

    // Reset with a write to 40 in flight.
    step(7'd0, 7'd0, 1, 7'd40, 1, 0, 0, '0, st);
    bus.issue_valid = 1'b1; bus.ra_addr = 7'd40;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_ra", bus.ra, '0);
    check("mid_rst_stall", {127'd0, bus.stall}, '0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    step(7'd40, 7'd3, 1, 7'd0, 0, 0, 0, '0, st);
    check("post_rst40", {127'd0, st}, '0);
    check("post_rst3", bus.rb, '0);
    step(7'd0, 7'd0, 0, 0, 0, 1, 7'd40, D40, st);
    step(7'd40, 7'd0, 0, 0, 0, 0, 0, '0, st);
    check("late_wb40", bus.ra, D40);

    // Random traffic over a small address window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      logic [6:0]   a, b, rt, wa;
      logic         v, rw, we;
      logic [127:0] wd;
      a  = 7'($urandom_range(0, 7));
      b  = 7'($urandom_range(0, 7));
      rt = 7'($urandom_range(0, 7));
      wa = 7'($urandom_range(0, 7));
      v  = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      we = ($urandom_range(0, 2) == 0);
      wd = {$urandom, $urandom, $urandom, $urandom};
      step(a, b, v, rt, rw, we, wa, wd, st);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
